md_unit_ctrl: RTL and testbench

Multiply/divide sequencer for the pipelined MIPS core. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the E stage and owns the HI/LO registers. It runs multi-cycle multiplies (fixed latency) and divides (iterative, one quotient bit per cycle), and raises a stall request when a later mult/div-class instruction reaches D while the unit is occupied.

---
 rtl/md_pkg.sv | 39 +++
 rtl/md_divider.sv | 42 ++++
 rtl/md_unit_ctrl.sv | 129 ++++++++++++
 tb/tb_md_unit_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: opcodes, FSM states, data width
// and the two's-complement sign helper used by the divide sign fix-up.
package md_pkg;

    localparam int MD_W = 32;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [2:0] OP_RSVD  = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } md_state_e;

    function automatic logic [MD_W-1:0] cond_neg(input logic [MD_W-1:0] a, input logic neg);
        return neg ? (~a + {{(MD_W-1){1'b0}}, 1'b1}) : a;
    endfunction

    // Low 64 bits of the product are identical for signed and unsigned once the
    // operands are extended accordingly.
    function automatic logic [2*MD_W-1:0] mul_ext(input logic [MD_W-1:0] a,
                                                  input logic [MD_W-1:0] b,
                                                  input logic            sgn);
        logic [2*MD_W-1:0] ax;
        logic [2*MD_W-1:0] bx;
        ax = {{MD_W{sgn & a[MD_W-1]}}, a};
        bx = {{MD_W{sgn & b[MD_W-1]}}, b};
        return ax * bx;
    endfunction

endpackage

// File: rtl/md_divider.sv
// 32-bit unsigned restoring divide core: one quotient bit per step.
// The dividend is shifted out of the quotient register as quotient bits shift in.
module md_divider
    import md_pkg::*;
(
    input  logic            clk,
    input  logic            load,
    input  logic            step,
    input  logic [MD_W-1:0] dividend,
    input  logic [MD_W-1:0] divisor,
    output logic [MD_W-1:0] quotient,
    output logic [MD_W-1:0] remainder
);

    logic [MD_W-1:0] q_q;
    logic [MD_W-1:0] rem_q;
    logic [MD_W-1:0] dvs_q;
    logic [MD_W:0]   trial;
    logic [MD_W-1:0] diff;
    logic            ge;

    // Partial remainder never exceeds 2*divisor, so a 33-bit trial value suffices
    // and the 32-bit difference is exact whenever the subtraction is taken.
    assign trial = {rem_q, q_q[MD_W-1]};
    assign ge    = (trial >= {1'b0, dvs_q});
    assign diff  = trial[MD_W-1:0] - dvs_q;

    always_ff @(posedge clk) begin
        if (load) begin
            q_q   <= dividend;
            rem_q <= '0;
            dvs_q <= divisor;
        end else if (step) begin
            q_q   <= {q_q[MD_W-2:0], ge};
            rem_q <= ge ? diff : trial[MD_W-1:0];
        end
    end

    assign quotient  = q_q;
    assign remainder = rem_q;

endmodule

// File: rtl/md_unit_ctrl.sv
// Multiply/divide sequencer owning HI/LO: fixed-latency multiply, 32-step divide
// plus one sign fix-up cycle, and the D-stage stall request for md-class hazards.
module md_unit_ctrl
    import md_pkg::*;
#(
    parameter int MULT_LAT  = 5,
    parameter int DIV_STEPS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_e,
    input  logic [31:0] rt_e,
    input  logic        md_in_d,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    md_state_e         state_q;
    logic [5:0]        cnt_q;
    logic              busy_q;
    logic [MD_W-1:0]   hi_q;
    logic [MD_W-1:0]   lo_q;
    logic [2*MD_W-1:0] prod_q;
    logic              sgn_a_q;
    logic              sgn_b_q;
    logic              div0_q;
    logic [MD_W-1:0]   raw_a_q;

    logic              div_load;
    logic              div_step;
    logic              is_sdiv;
    logic [MD_W-1:0]   div_a;
    logic [MD_W-1:0]   div_b;
    logic [MD_W-1:0]   quo;
    logic [MD_W-1:0]   rem;

    always_comb begin
        is_sdiv  = (op == OP_DIV);
        div_a    = cond_neg(rs_e, is_sdiv & rs_e[MD_W-1]);
        div_b    = cond_neg(rt_e, is_sdiv & rt_e[MD_W-1]);
        div_load = (state_q == S_IDLE) && start && (op == OP_DIV || op == OP_DIVU);
        div_step = (state_q == S_DIV);
    end

    md_divider u_div (
        .clk       (clk),
        .load      (div_load),
        .step      (div_step),
        .dividend  (div_a),
        .divisor   (div_b),
        .quotient  (quo),
        .remainder (rem)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                prod_q  <= mul_ext(rs_e, rt_e, op == OP_MULT);
                                cnt_q   <= 6'(MULT_LAT);
                                busy_q  <= 1'b1;
                                state_q <= S_MUL;
                            end
                            OP_DIV, OP_DIVU: begin
                                sgn_a_q <= is_sdiv & rs_e[MD_W-1];
                                sgn_b_q <= is_sdiv & rt_e[MD_W-1];
                                div0_q  <= (rt_e == '0);
                                raw_a_q <= rs_e;
                                cnt_q   <= 6'(DIV_STEPS);
                                busy_q  <= 1'b1;
                                state_q <= S_DIV;
                            end
                            OP_MTHI: hi_q <= rs_e;
                            OP_MTLO: lo_q <= rs_e;
                            OP_NONE, OP_RSVD: ;
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    cnt_q <= cnt_q - 6'd1;
                    if (cnt_q == 6'd1) begin
                        {hi_q, lo_q} <= prod_q;
                        busy_q       <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end
                S_DIV: begin
                    cnt_q <= cnt_q - 6'd1;
                    if (cnt_q == 6'd1) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    // Divide by zero returns all-ones quotient and the untouched dividend.
                    if (div0_q) begin
                        lo_q <= '1;
                        hi_q <= raw_a_q;
                    end else begin
                        lo_q <= cond_neg(quo, sgn_a_q ^ sgn_b_q);
                        hi_q <= cond_neg(rem, sgn_a_q);
                    end
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy  = busy_q;
    assign stall = md_in_d & (start | busy_q);
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Directed bench for md_unit_ctrl: multiply/divide results, latencies, stall and reset abort.
module tb_md_unit_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_e;
    logic [31:0] rt_e;
    logic        md_in_d;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int tests = 0;
    int fails = 0;
    int n;
    int stall_lo;

    always #5 clk = ~clk;

    md_unit_ctrl #(.MULT_LAT(5), .DIV_STEPS(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .rs_e    (rs_e),
        .rt_e    (rt_e),
        .md_in_d (md_in_d),
        .busy    (busy),
        .stall   (stall),
        .hi      (hi),
        .lo      (lo)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one md op for a single cycle; returns at the negedge after the issuing edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        rs_e  = a;
        rt_e  = b;
        @(negedge clk);
        start = 1'b0;
        op    = 3'd0;
    endtask

    task automatic wait_idle(output int cycles, output int stall_low);
        cycles    = 0;
        stall_low = 0;
        while (busy === 1'b1 && cycles < 100) begin
            if (stall !== 1'b1) stall_low++;
            cycles++;
            @(negedge clk);
        end
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        op      = 3'd0;
        rs_e    = '0;
        rt_e    = '0;
        md_in_d = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_stall", {31'b0, stall}, 32'h0);

        // MULT -3 * 7 with a dependent md op in D the whole time
        md_in_d = 1'b1;
        chk("idle_no_stall", {31'b0, stall}, 32'h0);
        @(negedge clk);
        start = 1'b1; op = 3'd1; rs_e = 32'hFFFFFFFD; rt_e = 32'd7;
        #1 chk("stall_start", {31'b0, stall}, 32'h1);
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        wait_idle(n, stall_lo);
        chk("mult_lat", n, 32'd5);
        chk("mult_stall_busy", stall_lo, 32'd0);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFEB);
        md_in_d = 1'b0;
        #1 chk("stall_clear", {31'b0, stall}, 32'h0);

        issue(3'd2, 32'hFFFFFFFF, 32'd2);
        wait_idle(n, stall_lo);
        chk("multu_lat", n, 32'd5);
        chk("multu_hi", hi, 32'h00000001);
        chk("multu_lo", lo, 32'hFFFFFFFE);

        issue(3'd4, 32'd100, 32'd7);
        wait_idle(n, stall_lo);
        chk("divu_lat", n, 32'd33);
        chk("divu_lo", lo, 32'h0000000E);
        chk("divu_hi", hi, 32'h00000002);

        issue(3'd3, 32'hFFFFFFF9, 32'd2);
        wait_idle(n, stall_lo);
        chk("div_neg_lo", lo, 32'hFFFFFFFD);
        chk("div_neg_hi", hi, 32'hFFFFFFFF);

        issue(3'd3, 32'd9, 32'hFFFFFFFE);
        wait_idle(n, stall_lo);
        chk("div_negb_lo", lo, 32'hFFFFFFFC);
        chk("div_negb_hi", hi, 32'h00000001);

        issue(3'd3, 32'h80000000, 32'hFFFFFFFF);
        wait_idle(n, stall_lo);
        chk("div_ovf_lo", lo, 32'h80000000);
        chk("div_ovf_hi", hi, 32'h00000000);

        issue(3'd4, 32'd5, 32'd0);
        wait_idle(n, stall_lo);
        chk("divu0_lat", n, 32'd33);
        chk("divu0_lo", lo, 32'hFFFFFFFF);
        chk("divu0_hi", hi, 32'h00000005);

        issue(3'd3, 32'hFFFFFFF9, 32'd0);
        wait_idle(n, stall_lo);
        chk("div0_lo", lo, 32'hFFFFFFFF);
        chk("div0_hi", hi, 32'hFFFFFFF9);

        issue(3'd5, 32'h1234ABCD, 32'h0);
        chk("mthi_hi", hi, 32'h1234ABCD);
        chk("mthi_busy", {31'b0, busy}, 32'h0);
        issue(3'd6, 32'h5A5A0001, 32'h0);
        chk("mtlo_lo", lo, 32'h5A5A0001);
        chk("mtlo_hi_kept", hi, 32'h1234ABCD);

        issue(3'd0, 32'hDEADBEEF, 32'h1);
        issue(3'd7, 32'hDEADBEEF, 32'h1);
        chk("nop_hi", hi, 32'h1234ABCD);
        chk("nop_lo", lo, 32'h5A5A0001);
        chk("nop_busy", {31'b0, busy}, 32'h0);

        // MULT offered on the second busy cycle of a divide must be dropped
        issue(3'd4, 32'd100, 32'd7);
        @(negedge clk);
        start = 1'b1; op = 3'd1; rs_e = 32'd2; rt_e = 32'd3;
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        wait_idle(n, stall_lo);
        chk("ign_lat", n + 2, 32'd33);
        chk("ign_lo", lo, 32'h0000000E);
        chk("ign_hi", hi, 32'h00000002);

        // Reset in the middle of a divide
        issue(3'd3, 32'hFFFFFFF9, 32'd2);
        repeat (9) @(negedge clk);
        chk("pre_rst_busy", {31'b0, busy}, 32'h1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_hi", hi, 32'h0);
        chk("abort_lo", lo, 32'h0);
        chk("abort_busy", {31'b0, busy}, 32'h0);
        repeat (40) @(negedge clk);
        chk("abort_stays_hi", hi, 32'h0);
        chk("abort_stays_lo", lo, 32'h0);
        issue(3'd1, 32'd2, 32'd3);
        wait_idle(n, stall_lo);
        chk("post_rst_lat", n, 32'd5);
        chk("post_rst_lo", lo, 32'h00000006);
        chk("post_rst_hi", hi, 32'h00000000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
